// File: rtl/nibble_serial_addsub_16_if.sv
// Operand/result handshake bundle for nibble_serial_addsub_16.
// Define OVF_FLAG_EN to add the signed-overflow flag (out_ovf).
interface nibble_serial_addsub_16_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic        in_sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_sum;
    logic        out_c;
`ifdef OVF_FLAG_EN
    logic        out_ovf;

    modport master (
        output in_valid, in_a, in_b, in_sub, out_ready,
        input  in_ready, out_valid, out_sum, out_c, out_ovf
    );
    modport slave (
        input  in_valid, in_a, in_b, in_sub, out_ready,
        output in_ready, out_valid, out_sum, out_c, out_ovf
    );
`else
    modport master (
        output in_valid, in_a, in_b, in_sub, out_ready,
        input  in_ready, out_valid, out_sum, out_c
    );
    modport slave (
        input  in_valid, in_a, in_b, in_sub, out_ready,
        output in_ready, out_valid, out_sum, out_c
    );
`endif
endinterface

// File: rtl/nibble_serial_addsub_16.sv
// 16-bit add/subtract computed one nibble per clock with a 4-bit carry-lookahead adder.
// Optional macro OVF_FLAG_EN adds a registered signed-overflow flag.
module nibble_serial_addsub_16 (
    input  logic                      clk,
    input  logic                      rst,
    nibble_serial_addsub_16_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  cnt_q;
    logic        carry_q;
    logic [15:0] a_q;
    logic [15:0] b_q;
    logic [11:0] res_q;
    logic [15:0] sum_q;
    logic        c_q;
    logic [4:0]  nib_s;
    logic        last_s;
`ifdef OVF_FLAG_EN
    logic        ovf_q;
`endif

    function automatic logic [4:0] cla4(input logic [3:0] a, input logic [3:0] b, input logic cin);
        logic [3:0] g;
        logic [3:0] p;
        logic [4:0] c;
        g    = a & b;
        p    = a ^ b;
        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & cin);
        return {c[4], p ^ c[3:0]};
    endfunction

    // Operands shift right so the active nibble always sits in bits [3:0].
    assign nib_s  = cla4(a_q[3:0], b_q[3:0], carry_q);
    assign last_s = (state_q == CALC) && (cnt_q == 2'd3);

    // Control state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    state_d = CALC;
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                if (cnt_q == 2'd3) begin
                    state_d = DONE;
                end else begin
                    state_d = CALC;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath: operand capture, nibble-serial accumulation, result publish on the last nibble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= 2'd0;
            carry_q <= 1'b0;
            a_q     <= 16'd0;
            b_q     <= 16'd0;
            res_q   <= 12'd0;
            sum_q   <= 16'd0;
            c_q     <= 1'b0;
`ifdef OVF_FLAG_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q     <= bus.in_a;
                        b_q     <= bus.in_sub ? ~bus.in_b : bus.in_b;
                        carry_q <= bus.in_sub;
                        cnt_q   <= 2'd0;
                    end
                end
                CALC: begin
                    a_q     <= {4'd0, a_q[15:4]};
                    b_q     <= {4'd0, b_q[15:4]};
                    res_q   <= {nib_s[3:0], res_q[11:4]};
                    carry_q <= nib_s[4];
                    cnt_q   <= cnt_q + 2'd1;
                    if (last_s) begin
                        sum_q <= {nib_s[3:0], res_q};
                        c_q   <= nib_s[4];
`ifdef OVF_FLAG_EN
                        // a_q[3]/b_q[3] hold the original sign bits of A and B' here.
                        ovf_q <= (a_q[3] == b_q[3]) & (nib_s[3] != a_q[3]);
`endif
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.out_sum   = sum_q;
    assign bus.out_c     = c_q;
`ifdef OVF_FLAG_EN
    assign bus.out_ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_nibble_serial_addsub_16.sv
// Directed self-checking bench for nibble_serial_addsub_16 (default build and OVF_FLAG_EN build).
module tb_nibble_serial_addsub_16;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    nibble_serial_addsub_16_if bus ();

    nibble_serial_addsub_16 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Called at #1 after an edge with the DUT idle; completes the whole handshake.
    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b, input logic sub,
                          input logic [15:0] es, input logic ec, input logic eo);
        int n;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_sub   = sub;
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        chk({tag, "_rdy_idle"}, {31'd0, bus.in_ready}, 32'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        chk({tag, "_rdy_calc"}, {31'd0, bus.in_ready}, 32'd0);
        n = 0;
        while (!bus.out_valid && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_latency"}, n, 32'd4);
        chk({tag, "_sum"}, {16'd0, bus.out_sum}, {16'd0, es});
        chk({tag, "_c"}, {31'd0, bus.out_c}, {31'd0, ec});
`ifdef OVF_FLAG_EN
        chk({tag, "_ovf"}, {31'd0, bus.out_ovf}, {31'd0, eo});
`endif
        @(posedge clk); #1;
        chk({tag, "_back_idle"}, {31'd0, bus.in_ready}, 32'd1);
    endtask

    initial begin
        int n;
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_a      = 16'd0;
        bus.in_b      = 16'd0;
        bus.in_sub    = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_sum", {16'd0, bus.out_sum}, 32'd0);
        chk("rst_c", {31'd0, bus.out_c}, 32'd0);
        #3 rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_ready", {31'd0, bus.in_ready}, 32'd1);

        run_op("add_1234", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
        run_op("add_ffff", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_op("sub_5_7",  16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        run_op("sub_7_5",  16'h0007, 16'h0005, 1'b1, 16'h0002, 1'b1, 1'b0);
        run_op("add_7fff", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        run_op("sub_8000", 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        run_op("sub_0_0",  16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);
        run_op("add_8000", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);

        // Back-pressure: result must hold while in_valid stays high with other operands.
        bus.in_a      = 16'h0003;
        bus.in_b      = 16'h0004;
        bus.in_sub    = 1'b0;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        @(posedge clk); #1;
        bus.in_a = 16'h0010;
        bus.in_b = 16'h0020;
        n = 0;
        while (!bus.out_valid && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        chk("bp_latency", n, 32'd4);
        for (int i = 0; i < 5; i++) begin
            chk("bp_sum", {16'd0, bus.out_sum}, 32'h0007);
            chk("bp_valid", {31'd0, bus.out_valid}, 32'd1);
            chk("bp_ready", {31'd0, bus.in_ready}, 32'd0);
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_idle_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("bp_idle_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("bp_idle_sum", {16'd0, bus.out_sum}, 32'h0007);
        @(posedge clk); #1;
        chk("bp_accept", {31'd0, bus.in_ready}, 32'd0);
        bus.in_valid = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        chk("bp2_latency", n, 32'd4);
        chk("bp2_sum", {16'd0, bus.out_sum}, 32'h0030);
        @(posedge clk); #1;

        // Asynchronous reset mid-calculation (cnt = 2).
        bus.in_a     = 16'hAAAA;
        bus.in_b     = 16'h5555;
        bus.in_sub   = 1'b0;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        chk("arst_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("arst_sum", {16'd0, bus.out_sum}, 32'd0);
        chk("arst_ready", {31'd0, bus.in_ready}, 32'd1);
        #2 rst = 1'b0;
        @(posedge clk); #1;
        chk("arst_after_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("arst_after_valid", {31'd0, bus.out_valid}, 32'd0);
        run_op("post_rst", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/nibble_serial_addsub_16.md
NIBBLE_SERIAL_ADDSUB_16 -- requirements
Module: nibble_serial_addsub_16

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, named clk and rst.
REQ-002 The block SHALL have no parameters; operand width is fixed at 16 bits, processed as 4 nibbles.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  operand set on in_a/in_b/in_sub is valid.
REQ-006 in_ready  output  1  block can accept an operand set.
REQ-007 in_a  input  16  operand A.
REQ-008 in_b  input  16  operand B.
REQ-009 in_sub  input  1  0 = A+B, 1 = A-B.
REQ-010 out_valid  output  1  out_sum/out_c (and out_ovf) hold a result.
REQ-011 out_ready  input  1  downstream accepts the result.
REQ-012 out_sum  output  16  registered sum or difference.
REQ-013 out_c  output  1  carry out of bit 15; for subtract, 1 = no borrow.
REQ-014 out_ovf  output  1  signed overflow; present only with OVF_FLAG_EN.

Function
REQ-015 The FSM SHALL have states IDLE, CALC and DONE; in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-016 IDLE: on in_valid & in_ready at a rising edge, the block SHALL capture in_a, in_sub, and B' = in_sub ? ~in_b : in_b; set carry register = in_sub; clear nibble counter; go to CALC.
REQ-017 CALC: each edge, one 4-bit carry-lookahead add SHALL combine nibble[cnt] of A and B' with the carry register, write result nibble cnt, store carry out, and increment cnt.
REQ-018 CALC SHALL take exactly 4 edges (cnt 0..3); the edge processing cnt = 3 SHALL enter DONE with out_valid = 1.
REQ-019 Latency: out_valid SHALL rise 4 clock edges after the accepting edge.
REQ-020 out_c SHALL equal the carry out of nibble 3.
REQ-021 DONE: outputs SHALL hold stable while out_ready = 0; on out_valid & out_ready the block SHALL return to IDLE; out_sum/out_c SHALL keep their values until the next result.
REQ-022 No overlap: in_ready SHALL be 0 in CALC and DONE; in_valid there SHALL be ignored.
REQ-023 The earliest new acceptance SHALL be the edge after the IDLE return, giving a 6-cycle minimum per operation.
REQ-024 Arithmetic SHALL be modulo 2^16 and bit-exact to A + B' + in_sub.

Reset
REQ-025 Asserting rst SHALL immediately force IDLE, cnt = 0, carry = 0, out_sum = 0, out_c = 0, out_ovf = 0 and out_valid = 0, without waiting for clk.
REQ-026 Reset asserted in CALC or DONE SHALL abandon the operation; no partial result SHALL ever appear with out_valid = 1.
REQ-027 After rst deasserts, in_ready SHALL read 1 at the first subsequent edge.

Configuration
REQ-028 With macro OVF_FLAG_EN defined, out_ovf SHALL exist and equal (A[15] == B'[15]) & (out_sum[15] != A[15]), registered with out_sum.
REQ-029 Without OVF_FLAG_EN, the out_ovf port and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-030 add 0x1234 + 0x4321, out_ready = 1 -> out_sum = 0x5555, out_c = 0, out_valid exactly 4 edges after acceptance.
REQ-031 add 0xFFFF + 0x0001 -> out_sum = 0x0000, out_c = 1; with OVF_FLAG_EN, out_ovf = 0.
REQ-032 sub 0x0005 - 0x0007 -> out_sum = 0xFFFE, out_c = 0; sub 0x0007 - 0x0005 -> out_sum = 0x0002, out_c = 1.
REQ-033 out_ready held 0 for 5 cycles in DONE with in_valid = 1 throughout -> result stable, in_ready = 0, no new capture; after out_ready = 1, IDLE, then acceptance on the following edge.
REQ-034 rst pulsed asynchronously at cnt = 2 of add 0xAAAA + 0x5555 -> out_valid = 0 and out_sum = 0 immediately; the next op 0x0001 + 0x0001 -> 0x0002.
REQ-035 With OVF_FLAG_EN, add 0x7FFF + 0x0001 -> out_sum = 0x8000, out_ovf = 1; sub 0x8000 - 0x0001 -> out_sum = 0x7FFF, out_ovf = 1.
